cond_unit_banked: RTL and testbench

- Parametrised successor of the processor's condition-check / flag-register unit.
- Holds NZCV flags in NUM_BANKS banked copies, selected by processor mode (e.g. bank 0 user, bank 1 IRQ).
- Evaluates the 4-bit ARM condition field and gates PCSrc/RegWrite/MemWrite. Flag updates are gated by the condition result.
- Adds stall/flush handling, multi-cycle condition hold, an MSR-style flag write port, and an optional registered output stage.
- Sits between the decoder/ALU and the register file / data-memory write enables.

---
 rtl/cond_unit_banked.sv | 145 ++++++++++++++
 tb/tb_cond_unit_banked.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_banked.sv
// rtl/cond_unit_banked.sv - banked NZCV flag register with ARM condition evaluation and write-enable gating
module cond_unit_banked #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter bit NV_NEVER  = 1'b1,
    parameter bit REG_OUT   = 1'b0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [BANK_W-1:0] BankSel,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    input  logic [1:0]        FlagW,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Hold,
    input  logic              FlagWrEn,
    input  logic [3:0]        FlagWrData,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              CondEx,
    output logic [3:0]        Flags,
    output logic              C
);

    logic [NUM_BANKS-1:0][3:0] r_flags;
    logic                      r_condex_lat;
    logic [31:0]               w_bank_idx;
    logic [3:0]                w_flags;
    logic                      w_n, w_z, w_c, w_v;
    logic                      w_condex_raw;
    logic                      w_condex_eff;
    logic                      w_pcsrc;
    logic                      w_regwrite;
    logic                      w_memwrite;

    // Out-of-range bank selects fall back to bank 0.
    always_comb begin
        w_bank_idx = 32'(BankSel);
        if (w_bank_idx >= 32'(NUM_BANKS)) begin
            w_bank_idx = '0;
        end
        w_flags = r_flags[0];
        for (int b = 1; b < NUM_BANKS; b++) begin
            if (w_bank_idx == 32'(b)) begin
                w_flags = r_flags[b];
            end
        end
    end

    assign {w_n, w_z, w_c, w_v} = w_flags;

    always_comb begin
        w_condex_raw = 1'b0;
        case (Cond)
            4'h0: w_condex_raw = w_z;
            4'h1: w_condex_raw = ~w_z;
            4'h2: w_condex_raw = w_c;
            4'h3: w_condex_raw = ~w_c;
            4'h4: w_condex_raw = w_n;
            4'h5: w_condex_raw = ~w_n;
            4'h6: w_condex_raw = w_v;
            4'h7: w_condex_raw = ~w_v;
            4'h8: w_condex_raw = w_c & ~w_z;
            4'h9: w_condex_raw = ~w_c | w_z;
            4'hA: w_condex_raw = (w_n == w_v);
            4'hB: w_condex_raw = (w_n != w_v);
            4'hC: w_condex_raw = ~w_z & (w_n == w_v);
            4'hD: w_condex_raw = w_z | (w_n != w_v);
            4'hE: w_condex_raw = 1'b1;
            default: w_condex_raw = ~NV_NEVER;
        endcase
    end

    assign w_condex_eff = Hold ? r_condex_lat : w_condex_raw;

    // Enables before the stall gate; the registered path holds on stall instead.
    assign w_pcsrc    = PCS  & w_condex_eff & ~Flush;
    assign w_regwrite = RegW & w_condex_eff & ~NoWrite & ~Flush;
    assign w_memwrite = MemW & w_condex_eff & ~Flush;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_flags      <= '0;
            r_condex_lat <= 1'b0;
        end else if (!Stall) begin
            if (!Hold) begin
                r_condex_lat <= w_condex_raw;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_idx == 32'(b)) begin
                    if (FlagWrEn) begin
                        r_flags[b] <= FlagWrData;
                    end else if (w_condex_eff && !Flush) begin
                        if (FlagW[1]) begin
                            r_flags[b][3:2] <= ALUFlags[3:2];
                        end
                        if (FlagW[0]) begin
                            r_flags[b][1:0] <= ALUFlags[1:0];
                        end
                    end
                end
            end
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic r_pcsrc, r_regwrite, r_memwrite, r_condex;

            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    r_pcsrc    <= 1'b0;
                    r_regwrite <= 1'b0;
                    r_memwrite <= 1'b0;
                    r_condex   <= 1'b0;
                end else if (!Stall) begin
                    r_pcsrc    <= w_pcsrc;
                    r_regwrite <= w_regwrite;
                    r_memwrite <= w_memwrite;
                    r_condex   <= w_condex_eff;
                end
            end

            assign PCSrc    = r_pcsrc;
            assign RegWrite = r_regwrite;
            assign MemWrite = r_memwrite;
            assign CondEx   = r_condex;
        end else begin : g_comb_out
            assign PCSrc    = w_pcsrc    & ~Stall & ~Reset;
            assign RegWrite = w_regwrite & ~Stall & ~Reset;
            assign MemWrite = w_memwrite & ~Stall & ~Reset;
            assign CondEx   = w_condex_eff & ~Reset;
        end
    endgenerate

    assign Flags = w_flags;
    assign C     = w_c;

endmodule

// File: tb/tb_cond_unit_banked.sv
// tb/tb_cond_unit_banked.sv - directed self-checking bench for cond_unit_banked
module tb_cond_unit_banked;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [0:0] BankSel;
    logic       PCS, RegW, MemW, NoWrite;
    logic [1:0] FlagW;
    logic [3:0] Cond, ALUFlags;
    logic       Stall, Flush, Hold, FlagWrEn;
    logic [3:0] FlagWrData;

    logic       c_pcsrc, c_regwrite, c_memwrite, c_condex, c_c;
    logic [3:0] c_flags;
    logic       r_pcsrc, r_regwrite, r_memwrite, r_condex, r_c;
    logic [3:0] r_flags;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_tbl;

    always #5 CLK = ~CLK;

    cond_unit_banked #(.NUM_BANKS(2), .BANK_W(1), .NV_NEVER(1'b1), .REG_OUT(1'b0)) u_comb (
        .CLK(CLK), .Reset(Reset), .BankSel(BankSel), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags), .Stall(Stall),
        .Flush(Flush), .Hold(Hold), .FlagWrEn(FlagWrEn), .FlagWrData(FlagWrData),
        .PCSrc(c_pcsrc), .RegWrite(c_regwrite), .MemWrite(c_memwrite), .CondEx(c_condex),
        .Flags(c_flags), .C(c_c)
    );

    cond_unit_banked #(.NUM_BANKS(2), .BANK_W(1), .NV_NEVER(1'b1), .REG_OUT(1'b1)) u_reg (
        .CLK(CLK), .Reset(Reset), .BankSel(BankSel), .PCS(PCS), .RegW(RegW), .MemW(MemW),
        .NoWrite(NoWrite), .FlagW(FlagW), .Cond(Cond), .ALUFlags(ALUFlags), .Stall(Stall),
        .Flush(Flush), .Hold(Hold), .FlagWrEn(FlagWrEn), .FlagWrData(FlagWrData),
        .PCSrc(r_pcsrc), .RegWrite(r_regwrite), .MemWrite(r_memwrite), .CondEx(r_condex),
        .Flags(r_flags), .C(r_c)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        BankSel = 1'b0; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; FlagW = 2'b00;
        Cond = 4'hE; ALUFlags = 4'h0; Stall = 0; Flush = 0; Hold = 0;
        FlagWrEn = 0; FlagWrData = 4'h0;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        PCS = 1; RegW = 1; MemW = 1;
        @(negedge CLK); #1;
        chk("rst_regwrite", {3'b0, c_regwrite}, 4'b0);
        chk("rst_pcsrc", {3'b0, c_pcsrc}, 4'b0);
        chk("rst_condex", {3'b0, c_condex}, 4'b0);
        chk("rst_flags", c_flags, 4'b0000);
        chk("rst_reg_pcsrc", {3'b0, r_pcsrc}, 4'b0);
        Reset = 1'b0;
        idle();

        // SUBS setting Z, then EQ / NE
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; #1;
        chk("t1_subs_regwrite", {3'b0, c_regwrite}, 4'b1);
        tick();
        idle();
        Cond = 4'h0; RegW = 1; #1;
        chk("t1_flags", c_flags, 4'b0100);
        chk("t1_eq_regwrite", {3'b0, c_regwrite}, 4'b1);
        NoWrite = 1; #1;
        chk("t1_nowrite", {3'b0, c_regwrite}, 4'b0);
        NoWrite = 0; Cond = 4'h1; #1;
        chk("t1_ne_regwrite", {3'b0, c_regwrite}, 4'b0);
        exp_tbl = 16'h66A9;
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i); #1;
            chk($sformatf("t1_decode_z_cond%0d", i), {3'b0, c_condex}, {3'b0, exp_tbl[i]});
        end

        // bank isolation
        idle();
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1000;
        tick();
        idle();
        #1;
        chk("t2_bank0_flags", c_flags, 4'b1000);
        BankSel = 1'b1; Cond = 4'h4; RegW = 1; #1;
        chk("t2_bank1_flags", c_flags, 4'b0000);
        chk("t2_bank1_mi", {3'b0, c_regwrite}, 4'b0);
        BankSel = 1'b0; #1;
        chk("t2_back_flags", c_flags, 4'b1000);
        chk("t2_back_mi", {3'b0, c_regwrite}, 4'b1);

        // conditional flag gating
        idle();
        FlagWrEn = 1; FlagWrData = 4'b0000;
        tick();
        idle();
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1; #1;
        chk("t3_addseq_regwrite", {3'b0, c_regwrite}, 4'b0);
        tick();
        chk("t3_addseq_flags", c_flags, 4'b0000);
        Cond = 4'hE;
        tick();
        chk("t3_addsal_flags", c_flags, 4'b1111);

        // hold of latched condition
        idle();
        Cond = 4'h0; MemW = 1; #1;
        chk("t4_latch_condex", {3'b0, c_condex}, 4'b1);
        tick();
        Hold = 1; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b0000; #1;
        chk("t4_hold1_memwrite", {3'b0, c_memwrite}, 4'b1);
        tick();
        chk("t4_hold_flags", c_flags, 4'b0011);
        FlagW = 2'b00; Cond = 4'h0; #1;
        chk("t4_hold2_condex", {3'b0, c_condex}, 4'b1);
        chk("t4_hold2_memwrite", {3'b0, c_memwrite}, 4'b1);
        tick();
        chk("t4_hold3_memwrite", {3'b0, c_memwrite}, 4'b1);
        Reset = 1; #1;
        chk("t4_rst_condex", {3'b0, c_condex}, 4'b0);
        chk("t4_rst_memwrite", {3'b0, c_memwrite}, 4'b0);
        chk("t4_rst_flags", c_flags, 4'b0000);
        @(negedge CLK);
        Reset = 0; #1;
        chk("t4_post_rst_condex", {3'b0, c_condex}, 4'b0);

        // stall, flush, MSR priority
        idle();
        Stall = 1; FlagW = 2'b11; ALUFlags = 4'b1111; PCS = 1; RegW = 1; MemW = 1; #1;
        chk("t5_stall_enables", {1'b0, c_pcsrc, c_regwrite, c_memwrite}, 4'b0000);
        tick();
        chk("t5_stall_flags", c_flags, 4'b0000);
        idle();
        Flush = 1; FlagWrEn = 1; FlagWrData = 4'b0011; FlagW = 2'b11; ALUFlags = 4'b1100; RegW = 1; #1;
        chk("t5_flush_regwrite", {3'b0, c_regwrite}, 4'b0);
        tick();
        chk("t5_flush_msr_flags", c_flags, 4'b0011);
        idle();
        FlagWrEn = 1; FlagWrData = 4'b1010; FlagW = 2'b11; ALUFlags = 4'b0101;
        tick();
        chk("t5_msr_priority", c_flags, 4'b1010);
        chk("t5_carry_out", {3'b0, c_c}, 4'b1);
        idle();
        Flush = 1; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        chk("t5_flush_blocks_alu", c_flags, 4'b1010);
        idle();
        exp_tbl = 16'h6996;
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i); #1;
            chk($sformatf("t5_decode_nc_cond%0d", i), {3'b0, c_condex}, {3'b0, exp_tbl[i]});
        end

        // registered outputs
        idle();
        Cond = 4'hF; PCS = 1;
        tick();
        chk("t6_nv_pcsrc", {3'b0, r_pcsrc}, 4'b0);
        Cond = 4'hE; #1;
        chk("t6_latency_pcsrc", {3'b0, r_pcsrc}, 4'b0);
        tick();
        chk("t6_al_pcsrc", {3'b0, r_pcsrc}, 4'b1);
        chk("t6_al_condex", {3'b0, r_condex}, 4'b1);
        Flush = 1;
        tick();
        chk("t6_flush_pcsrc", {3'b0, r_pcsrc}, 4'b0);
        Flush = 0;
        tick();
        chk("t6_reload_pcsrc", {3'b0, r_pcsrc}, 4'b1);
        Stall = 1; PCS = 0;
        tick();
        chk("t6_stall_hold_pcsrc", {3'b0, r_pcsrc}, 4'b1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
